// File: rtl/ring_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ring_addr_gen                                                |
// | Description : Circular-buffer address generator for an external RAM of any |
// |               depth (power of two or not). FIFO mode tracks occupancy with |
// |               full/empty flags; delay-line mode makes the read address     |
// |               trail the write address by a programmable, clamped offset.   |
// | Ports       : clk, rst_n (async, active low), clr (sync clear), mode       |
// |               (0 FIFO / 1 delay line), delay, wr_en, rd_en in;             |
// |               wr_addr, rd_addr, count, full, empty, dly_valid, wr_wrap,    |
// |               rd_wrap, ovf, udf out. Every output is a register.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ring_addr_gen #(
  parameter  int DEPTH = 48,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          mode,
  input  logic [AW-1:0] delay,
  input  logic          wr_en,
  input  logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          dly_valid,
  output logic          wr_wrap,
  output logic          rd_wrap,
  output logic          ovf,
  output logic          udf
);

  localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);
  // DEPTH folded into AW bits (0 for power-of-two depths); the wrapped
  // subtraction below only needs it modulo 2^AW since the result is < DEPTH.
  localparam logic [AW-1:0] c_DEPTH_LO = AW'(DEPTH);
  localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_ONE      = (AW+1)'(1);

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          r_full;
  logic          r_empty;
  logic          r_dly_valid;
  logic          r_wr_wrap;
  logic          r_rd_wrap;
  logic          r_ovf;
  logic          r_udf;
  logic          r_mode;

  logic [AW-1:0] w_d;
  logic [AW:0]   w_d_x;
  logic          w_mode_chg;
  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [AW-1:0] w_wr_nxt;
  logic [AW-1:0] w_rd_nxt;
  logic [AW:0]   w_cnt_nxt;
  logic          w_full_nxt;
  logic          w_empty_nxt;
  logic          w_dv_nxt;
  logic          w_wwrap_nxt;
  logic          w_rwrap_nxt;
  logic          w_ovf_nxt;
  logic          w_udf_nxt;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == c_LAST) ? '0 : p + 1'b1;
  endfunction

  // Offsets at or beyond the ring size clamp to the largest usable delay.
  assign w_d        = ({1'b0, delay} >= c_DEPTH) ? c_LAST : delay;
  assign w_d_x      = {1'b0, w_d};
  assign w_mode_chg = mode ^ r_mode;
  assign w_wr_acc   = wr_en & ~r_full;
  assign w_rd_acc   = rd_en & ~r_empty;

  always_comb begin
    w_wr_nxt    = r_wr_ptr;
    w_rd_nxt    = r_rd_ptr;
    w_cnt_nxt   = r_cnt;
    w_full_nxt  = 1'b0;
    w_empty_nxt = 1'b0;
    w_dv_nxt    = 1'b0;
    w_wwrap_nxt = 1'b0;
    w_rwrap_nxt = 1'b0;
    w_ovf_nxt   = 1'b0;
    w_udf_nxt   = 1'b0;
    if (!r_mode) begin
      if (w_wr_acc) begin
        w_wr_nxt    = f_inc(r_wr_ptr);
        w_wwrap_nxt = (r_wr_ptr == c_LAST);
      end
      if (w_rd_acc) begin
        w_rd_nxt    = f_inc(r_rd_ptr);
        w_rwrap_nxt = (r_rd_ptr == c_LAST);
      end
      if (w_wr_acc && !w_rd_acc) begin
        w_cnt_nxt = r_cnt + c_ONE;
      end else if (w_rd_acc && !w_wr_acc) begin
        w_cnt_nxt = r_cnt - c_ONE;
      end
      w_full_nxt  = (w_cnt_nxt == c_DEPTH);
      w_empty_nxt = (w_cnt_nxt == '0);
      w_ovf_nxt   = wr_en & r_full;
      w_udf_nxt   = rd_en & r_empty;
    end else begin
      if (wr_en) begin
        w_wr_nxt    = f_inc(r_wr_ptr);
        w_wwrap_nxt = (r_wr_ptr == c_LAST);
      end
      // Read address trails the upcoming write address by d, wrapping below 0.
      w_rd_nxt    = (w_wr_nxt >= w_d) ? (w_wr_nxt - w_d)
                                      : (w_wr_nxt + c_DEPTH_LO - w_d);
      w_rwrap_nxt = (r_rd_ptr == c_LAST) && (w_rd_nxt == '0);
      // Clamp first so a shrinking delay pulls the count straight down to d.
      if (r_cnt >= w_d_x) begin
        w_cnt_nxt = w_d_x;
      end else if (wr_en) begin
        w_cnt_nxt = r_cnt + c_ONE;
      end
      w_dv_nxt = (w_cnt_nxt >= w_d_x);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_empty     <= 1'b1;
      r_dly_valid <= 1'b0;
      r_wr_wrap   <= 1'b0;
      r_rd_wrap   <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_mode      <= 1'b0;
    end else if (clr || w_mode_chg) begin
      // The access presented alongside a clear is dropped.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_full      <= 1'b0;
      r_empty     <= ~mode;
      r_dly_valid <= 1'b0;
      r_wr_wrap   <= 1'b0;
      r_rd_wrap   <= 1'b0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_mode      <= mode;
    end else begin
      r_wr_ptr    <= w_wr_nxt;
      r_rd_ptr    <= w_rd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_full      <= w_full_nxt;
      r_empty     <= w_empty_nxt;
      r_dly_valid <= w_dv_nxt;
      r_wr_wrap   <= w_wwrap_nxt;
      r_rd_wrap   <= w_rwrap_nxt;
      r_ovf       <= w_ovf_nxt;
      r_udf       <= w_udf_nxt;
    end
  end

  assign wr_addr   = r_wr_ptr;
  assign rd_addr   = r_rd_ptr;
  assign count     = r_cnt;
  assign full      = r_full;
  assign empty     = r_empty;
  assign dly_valid = r_dly_valid;
  assign wr_wrap   = r_wr_wrap;
  assign rd_wrap   = r_rd_wrap;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule
`default_nettype wire

// File: doc/ring_addr_gen.md
# ring_addr_gen

Parametrised circular-buffer address generator for single-port or dual-port RAMs of any depth, including non-power-of-two depths such as 48. It produces write and read addresses with explicit wrap handling, so no `%` operator and no power-of-two mask is required. It supports two modes: FIFO mode, with occupancy tracking and full/empty flags, and delay-line mode, where the read address trails the write address by a programmable offset. It sits between stream logic and a RAM macro; the RAM itself is external.

## Interface
Parameters:
- DEPTH, 48: number of RAM entries; any integer ≥ 2.
- AW, $clog2(DEPTH): address width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of pointers, count and flags (same values as reset).
- mode  in  1  0 = FIFO, 1 = delay line.
- delay  in  AW  delay-line offset in entries; used only when mode = 1.
- wr_en  in  1  write request.
- rd_en  in  1  read request; ignored when mode = 1.
- wr_addr  out  AW  address for the current write.
- rd_addr  out  AW  address for the current read.
- count  out  AW+1  FIFO mode: occupancy. Delay mode: writes since clear, saturating at the effective delay.
- full  out  1  count == DEPTH (FIFO mode only; 0 in delay mode).
- empty  out  1  count == 0 (FIFO mode only; 0 in delay mode).
- dly_valid  out  1  delay mode: count ≥ effective delay, so rd_addr holds valid data.
- wr_wrap  out  1  one-cycle pulse on the edge where wr_addr steps DEPTH-1 → 0.
- rd_wrap  out  1  one-cycle pulse on the edge where rd_addr steps DEPTH-1 → 0.
- ovf  out  1  one-cycle pulse: write requested while full (FIFO mode).
- udf  out  1  one-cycle pulse: read requested while empty (FIFO mode).

## Operation
- Pointer increment: next = (ptr == DEPTH-1) ? 0 : ptr + 1. For power-of-two DEPTH the result is identical to `(ptr+1) & (DEPTH-1)`.
- FIFO mode:
  - A write is accepted when wr_acc = wr_en & ~full.
  - A read is accepted when rd_acc = rd_en & ~empty.
  - count updates as follows: +1 on write only, -1 on read only, unchanged on both or neither.
  - Simultaneous write and read when full: the read is accepted and the write is rejected; ovf pulses and count becomes DEPTH-1.
  - Simultaneous write and read when empty: the write is accepted and the read is rejected; udf pulses and count becomes 1.
  - A rejected access leaves its pointer unchanged.
- Delay mode:
  - Effective delay: d = (delay ≥ DEPTH) ? DEPTH-1 : delay.
  - wr_addr advances on every wr_en.
  - rd_addr = (wr_addr ≥ d) ? wr_addr − d : wr_addr + DEPTH − d. This is computed from the next wr_addr and registered.
  - count increments on each wr_en and saturates at d; dly_valid = (count ≥ d). With d = 0, dly_valid = 1 and rd_addr == wr_addr.
  - ovf and udf are held at 0.
- Mode change: when mode differs from its registered copy, the next edge applies a clear (as clr). The access requested in that cycle is dropped.
- Priority: rst_n > clr > mode-change clear > normal operation.
- Reset values: wr_addr = 0, rd_addr = 0, count = 0, full = 0, dly_valid = 0, wr_wrap = rd_wrap = ovf = udf = 0. empty = 1 if mode = 0 at reset exit, and 0 in delay mode. The registered mode copy resets to 0.

## Timing
- All outputs are registered; no combinational path runs from inputs to outputs.
- The addresses are valid in the cycle the request is presented; the RAM uses wr_addr/rd_addr alongside wr_en/rd_en.
- Pointers, count and flags update on the edge that accepts the access. full and empty reflect the new count in the following cycle.
- wr_wrap, rd_wrap, ovf and udf are high for exactly the one cycle after the triggering edge.
- A change on delay takes effect on rd_addr one edge later, with no clear. dly_valid is re-evaluated against the new d on that same edge.
- An rst_n assertion mid-operation forces reset values immediately, without waiting for a clock. Release is synchronised externally.

## Test plan
- FIFO fill, DEPTH=48: 48 consecutive writes → wr_addr 0..47; wr_wrap pulses after the 48th write; count = 48, full = 1. A 49th write → ovf pulses, wr_addr stays 0.
- Simultaneous access: at count = 48, wr_en = rd_en = 1 → count 47, rd_addr +1, wr_addr unchanged, ovf = 1. At count = 0, both asserted → count 1, wr_addr +1, udf = 1.
- Delay mode, d = 16: wr_en held high → dly_valid rises after 16 writes. When wr_addr = 5, rd_addr = 37; rd_wrap pulses on the rd_addr 47 → 0 step.
- Delay clamp and zero: delay = 60 → rd_addr = wr_addr − 47 mod 48. delay = 0 → rd_addr == wr_addr and dly_valid = 1 from the first cycle.
- Clears: toggle mode at count = 20 → all state returns to reset values next cycle and the pending access is dropped. Assert rst_n low between edges → outputs go to reset values immediately.
- DEPTH=64 instance: 200 writes in delay mode with d = 16 → rd_addr == (48 + wr_addr) & 63 on every cycle after dly_valid rises.
